// File: rtl/joymega_responder.sv
// Sega six-button pad responder for one MSX joystick port. Counts falling
// edges on the pin-8 select line, returns to phase 0 after an idle timeout,
// and answers each select phase with the matching active-low pin levels.
module joymega_responder #(
  parameter int CLK_HZ     = 21_477_270,
  parameter int TIMEOUT_US = 1500,
  parameter bit SIX_BUTTON = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       sel,
  input  logic       pad_up,
  input  logic       pad_down,
  input  logic       pad_left,
  input  logic       pad_right,
  input  logic       pad_a,
  input  logic       pad_b,
  input  logic       pad_x,
  input  logic       pad_y,
  input  logic       pad_l1,
  input  logic       pad_r1,
  input  logic       pad_se,
  input  logic       pad_st,
  output logic [5:0] joy_n,
  output logic [2:0] phase
);

  localparam int TIMEOUT_CYC = (CLK_HZ / 1000) * TIMEOUT_US / 1000;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYC);

  // Mega Drive button names mapped from the Pocket pad layout
  logic md_a, md_b, md_c, md_x, md_y, md_z, md_start, md_mode;
  assign md_a     = pad_y;
  assign md_b     = pad_b;
  assign md_c     = pad_a;
  assign md_x     = pad_x;
  assign md_y     = pad_l1;
  assign md_z     = pad_r1;
  assign md_start = pad_st;
  assign md_mode  = pad_se;

  logic          sel_q;
  logic [2:0]    cnt;
  logic [2:0]    cnt_d;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_d;
  logic [5:0]    pins_d;
  logic          fall_edge;
  logic          any_edge;

  assign fall_edge = sel_q & ~sel;
  assign any_edge  = sel ^ sel_q;

  // Next phase count and idle timer; an edge always beats the timeout
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d   = cnt;
    timer_d = timer;
    if (any_edge) begin
      timer_d = '0;
      if (fall_edge && cnt != 3'd4) cnt_d = cnt + 3'd1;
    end else if (timer == TIMEOUT_VAL) begin
      cnt_d = 3'd0;
    end else begin
      timer_d = timer + TW'(1);
    end
    if (!SIX_BUTTON) cnt_d = 3'd0;
  end

  // Active-high pin image {p7, p6, R, L, D, U} for the upcoming phase
  always_comb begin
    pins_d = {md_c, md_b, pad_right, pad_left, pad_down, pad_up};
    if (sel) begin
      if (cnt_d == 3'd3) pins_d = {md_c, md_b, md_mode, md_x, md_y, md_z};
    end else begin
      unique case (cnt_d)
        3'd3:    pins_d = {md_start, md_a, 4'b1111};
        3'd4:    pins_d = {md_start, md_a, 4'b0000};
        default: pins_d = {md_start, md_a, 2'b11, pad_down, pad_up};
      endcase
    end
  end

  // State and registered port pins
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      sel_q <= 1'b1;
      cnt   <= 3'd0;
      timer <= '0;
      joy_n <= 6'b111111;
    end else begin
      sel_q <= sel;
      cnt   <= cnt_d;
      timer <= timer_d;
      joy_n <= ~pins_d;
    end
  end

  assign phase = cnt;

endmodule

// File: tb/tb_joymega_responder.sv
// Self-checking bench for joymega_responder: directed protocol steps plus
// randomized select/pad traffic, checked against a cycle-level behavioural
// model of the six-button protocol. A second instance runs in 3-button mode.
module tb_joymega_responder;

  localparam int CLK_HZ      = 1_000_000;
  localparam int TIMEOUT_US  = 100;
  localparam int TIMEOUT_CYC = (CLK_HZ / 1000) * TIMEOUT_US / 1000;

  logic clk = 1'b0;
  logic reset, sel;
  logic pad_up, pad_down, pad_left, pad_right;
  logic pad_a, pad_b, pad_x, pad_y, pad_l1, pad_r1, pad_se, pad_st;
  logic [5:0] joy_n_6, joy_n_3;
  logic [2:0] phase_6, phase_3;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int         cycle      = 0;
  int         last_event = 0;
  int         m_cnt      = 0;
  logic       m_sel_q    = 1'b1;
  logic [5:0] m_joy6     = 6'h3F;
  logic [5:0] m_joy3     = 6'h3F;

  always #5 clk = ~clk;

  joymega_responder #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US), .SIX_BUTTON(1'b1)) dut6 (
    .clk_sys(clk), .reset(reset), .sel(sel),
    .pad_up(pad_up), .pad_down(pad_down), .pad_left(pad_left), .pad_right(pad_right),
    .pad_a(pad_a), .pad_b(pad_b), .pad_x(pad_x), .pad_y(pad_y),
    .pad_l1(pad_l1), .pad_r1(pad_r1), .pad_se(pad_se), .pad_st(pad_st),
    .joy_n(joy_n_6), .phase(phase_6)
  );

  joymega_responder #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US), .SIX_BUTTON(1'b0)) dut3 (
    .clk_sys(clk), .reset(reset), .sel(sel),
    .pad_up(pad_up), .pad_down(pad_down), .pad_left(pad_left), .pad_right(pad_right),
    .pad_a(pad_a), .pad_b(pad_b), .pad_x(pad_x), .pad_y(pad_y),
    .pad_l1(pad_l1), .pad_r1(pad_r1), .pad_se(pad_se), .pad_st(pad_st),
    .joy_n(joy_n_3), .phase(phase_3)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Pin image straight from the protocol table, active-high {p7,p6,R,L,D,U}
  function automatic logic [5:0] md_pins(input logic s, input int c);
    if (s && c == 3)  return {pad_a, pad_b, pad_se, pad_x, pad_l1, pad_r1};
    if (s)            return {pad_a, pad_b, pad_right, pad_left, pad_down, pad_up};
    if (c == 3)       return {pad_st, pad_y, 4'b1111};
    if (c == 4)       return {pad_st, pad_y, 4'b0000};
    return {pad_st, pad_y, 2'b11, pad_down, pad_up};
  endfunction

  // One clock: advance the model on the edge, then compare both instances
  task automatic tick();
    @(posedge clk);
    cycle++;
    if (reset) begin
      m_sel_q    = 1'b1;
      m_cnt      = 0;
      last_event = cycle;
      m_joy6     = 6'h3F;
      m_joy3     = 6'h3F;
    end else begin
      if (sel != m_sel_q) begin
        last_event = cycle;
        if (!sel) m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
      end else if (cycle - last_event > TIMEOUT_CYC) begin
        m_cnt = 0;
      end
      m_sel_q = sel;
      m_joy6  = ~md_pins(sel, m_cnt);
      m_joy3  = ~md_pins(sel, 0);
    end
    #1;
    check("model_joy_n", {2'b00, joy_n_6}, {2'b00, m_joy6});
    check("model_phase", {5'b0, phase_6}, 8'(m_cnt));
    check("three_btn_joy_n", {2'b00, joy_n_3}, {2'b00, m_joy3});
    check("three_btn_phase", {5'b0, phase_3}, 8'd0);
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_pads();
    {pad_up, pad_down, pad_left, pad_right, pad_a, pad_b,
     pad_x, pad_y, pad_l1, pad_r1, pad_se, pad_st} = 12'b0;
  endtask

  task automatic rand_pads();
    {pad_up, pad_down, pad_left, pad_right, pad_a, pad_b,
     pad_x, pad_y, pad_l1, pad_r1, pad_se, pad_st} = 12'($urandom);
  endtask

  logic [5:0] exp_low [4] = '{6'b110011, 6'b110011, 6'b110000, 6'b111111};
  int len;

  initial begin
    // Reset with sel high and nothing pressed
    reset = 1'b1;
    sel   = 1'b1;
    clear_pads();
    tick();
    check("reset_joy_n", {2'b00, joy_n_6}, 8'h3F);
    check("reset_phase", {5'b0, phase_6}, 8'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_joy_n", {2'b00, joy_n_6}, 8'h3F);
    check("post_reset_phase", {5'b0, phase_6}, 8'd0);

    // Up + C with sel high, then Start in the first low phase
    pad_up = 1'b1;
    pad_a  = 1'b1;
    tick();
    check("up_c_joy_n", {2'b00, joy_n_6}, 8'b00011110);
    clear_pads();
    pad_st = 1'b1;
    sel    = 1'b0;
    tick();
    check("start_joy_n", {2'b00, joy_n_6}, 8'b00010011);
    check("start_phase", {5'b0, phase_6}, 8'd1);
    sel = 1'b1;
    clear_pads();
    hold(110);

    // Full four-phase sequence with nothing pressed
    for (int i = 0; i < 4; i++) begin
      sel = 1'b0;
      tick();
      check("seq_low_joy_n", {2'b00, joy_n_6}, {2'b00, exp_low[i]});
      check("seq_low_phase", {5'b0, phase_6}, 8'(i + 1));
      hold(9);
      sel = 1'b1;
      tick();
      hold(9);
    end
    hold(110);

    // Repeat with X+Z held: extra buttons appear in the high phase at count 3
    pad_x  = 1'b1;
    pad_r1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = 1'b0;
      tick();
      hold(9);
      sel = 1'b1;
      tick();
      if (i == 2) check("xz_high_joy_n", {2'b00, joy_n_6}, 8'b00111010);
      hold(9);
    end
    sel = 1'b0;
    tick();
    check("fourth_low_phase", {5'b0, phase_6}, 8'd4);
    clear_pads();

    // Idle timeout: count survives 101 cycles, clears on the 102nd
    hold(100);
    check("timeout_101_phase", {5'b0, phase_6}, 8'd4);
    tick();
    check("timeout_102_phase", {5'b0, phase_6}, 8'd0);

    // Edges arriving while the timer reads 99 keep the count alive
    sel = 1'b1;
    tick();
    hold(9);
    sel = 1'b0;
    tick();
    check("t99_start_phase", {5'b0, phase_6}, 8'd1);
    hold(99);
    sel = 1'b1;
    tick();
    check("t99_rise_phase", {5'b0, phase_6}, 8'd1);
    hold(99);
    sel = 1'b0;
    tick();
    check("t99_fall_phase", {5'b0, phase_6}, 8'd2);

    // Falling edge on the exact timeout cycle: edge wins
    sel = 1'b1;
    tick();
    hold(100);
    check("pre_timeout_phase", {5'b0, phase_6}, 8'd2);
    sel = 1'b0;
    tick();
    check("edge_on_timeout_phase", {5'b0, phase_6}, 8'd3);

    // Randomized select traffic, pad changes and occasional resets
    for (int k = 0; k < 60; k++) begin
      sel = ~sel;
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(95, 110))
                                        : int'($urandom_range(1, 15));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) rand_pads();
        reset = ($urandom_range(0, 149) == 0);
        tick();
      end
      reset = 1'b0;
    end

    // Mid-sequence reset, then three-button instance with X held
    sel = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_reset_phase", {5'b0, phase_6}, 8'd0);
    check("mid_reset_joy_n", {2'b00, joy_n_6}, 8'h3F);
    reset = 1'b0;
    sel   = 1'b1;
    clear_pads();
    pad_x = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      sel = 1'b0;
      for (int j = 0; j < 10; j++) begin
        tick();
        check("three_btn_no_six_id", {7'b0, joy_n_3[3:0] == 4'b0000}, 8'd0);
      end
      check("three_btn_low_joy_n", {2'b00, joy_n_3}, 8'b00110011);
      sel = 1'b1;
      for (int j = 0; j < 10; j++) tick();
      check("three_btn_high_joy_n", {2'b00, joy_n_3}, 8'b00111111);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
